// File: rtl/csa_accum.sv
// Multi-beat carry-save accumulator: three-operand beats are folded into a redundant
// sum/carry pair, then resolved through one registered carry-propagate stage on the last beat.
module csa_accum #(
  parameter int W     = 8,
  parameter int GUARD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_a,
  input  logic [W-1:0]         in_b,
  input  logic [W-1:0]         in_c,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W+GUARD-1:0]   out_sum,
  output logic                 out_ovf
);

  localparam int ACC_W = W + GUARD;

  // state   | meaning
  // ACCUM   | accepting beats, in_ready high
  // RESOLVE | one-cycle carry-propagate of S + C into out_sum
  // HOLD    | result presented, waiting for out_ready
  typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

  state_t             state;
  logic [ACC_W-1:0]   s_acc, c_acc;
  logic               first, ovf_st;

  logic [ACC_W-1:0]   s_in, c_in, ax, bx, cx;
  logic [ACC_W-1:0]   s1, k1, c1, s2, k2, c2, s3, k3, c3;
  logic               drop, ovf_next;
  logic [ACC_W:0]     sum_full;

  always_comb begin
    s_in = first ? '0 : s_acc;
    c_in = first ? '0 : c_acc;
    ax   = {{GUARD{1'b0}}, in_a};
    bx   = {{GUARD{1'b0}}, in_b};
    cx   = {{GUARD{1'b0}}, in_c};

    s1 = s_in ^ c_in ^ ax;
    k1 = (s_in & c_in) | (s_in & ax) | (c_in & ax);
    c1 = {k1[ACC_W-2:0], 1'b0};

    s2 = s1 ^ c1 ^ bx;
    k2 = (s1 & c1) | (s1 & bx) | (c1 & bx);
    c2 = {k2[ACC_W-2:0], 1'b0};

    s3 = s2 ^ c2 ^ cx;
    k3 = (s2 & c2) | (s2 & cx) | (c2 & cx);
    c3 = {k3[ACC_W-2:0], 1'b0};

    // A dropped carry is worth 2^ACC_W; all terms are non-negative, so overflow is certain.
    drop     = k1[ACC_W-1] | k2[ACC_W-1] | k3[ACC_W-1];
    ovf_next = (first ? 1'b0 : ovf_st) | drop;

    sum_full = {1'b0, s_acc} + {1'b0, c_acc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ACCUM;
      s_acc   <= '0;
      c_acc   <= '0;
      first   <= 1'b1;
      ovf_st  <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            s_acc  <= s3;
            c_acc  <= c3;
            ovf_st <= ovf_next;
            first  <= 1'b0;
            if (in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_sum <= sum_full[ACC_W-1:0];
          out_ovf <= ovf_st | sum_full[ACC_W];
          state   <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            state  <= ACCUM;
            first  <= 1'b1;
            s_acc  <= '0;
            c_acc  <= '0;
            ovf_st <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

endmodule

// File: doc/csa_accum.md
# csa_accum

Parametrised, multi-beat carry-save accumulator. It sums a packet of any number of beats. Each beat carries three W-bit unsigned operands. The running total is kept in redundant sum/carry form, so there is no carry propagation per beat. On the last beat the block resolves the total through one registered carry-propagate stage and presents it on a valid/ready output with an exact overflow flag. It is the next generation of the team's fixed 8-bit, 3-operand registered CSA adder and sits in datapaths that reduce operand streams: dot-product tails and checksum engines.

## Interface
- W, 8, operand width.
- GUARD, 4, extra accumulator bits; ACC_W = W + GUARD.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_a, in_b, in_c  input  W each  unsigned operands, zero-extended to ACC_W.
- in_last  input  1  final beat of packet; qualified by in_valid.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_W  packet total modulo 2^ACC_W.
- out_ovf  output  1  true total >= 2^ACC_W.

## Operation
- States:
  - ACCUM: in_ready = 1.
  - RESOLVE: in_ready = 0, one cycle.
  - HOLD: out_valid = 1, in_ready = 0.
- Internal registers:
  - S, C: ACC_W-bit redundant accumulator.
  - first: set means the next beat starts a packet.
  - ovf_st: sticky overflow.
- Beat accepted (ACCUM and in_valid):
  - Compress the five vectors S, C, a, b, c to two with three full-adder CSA levels in one cycle.
  - When first = 1, S and C are treated as zero and ovf_st is treated as 0.
  - Carry vectors are shifted left by 1. Any carry bit shifted out of bit ACC_W-1 sets ovf_st.
  - first clears.
  - If in_last = 1, go to RESOLVE. Otherwise stay in ACCUM.
- ACCUM with in_valid = 0: hold all state, including between beats of a packet.
- RESOLVE:
  - out_sum <= (S + C) mod 2^ACC_W.
  - out_ovf <= ovf_st OR carry-out of S + C.
  - Go to HOLD.
- HOLD:
  - out_sum and out_ovf stay stable.
  - in_valid is ignored; the producer must hold its beat.
  - On out_ready = 1: go to ACCUM, set first, clear S, C and ovf_st.
- Arithmetic:
  - All unsigned.
  - out_sum is exact modulo 2^ACC_W.
  - out_ovf is exact: set if and only if the true packet sum is >= 2^ACC_W.
- Single-beat packet (in_last on the first beat) is legal.
- Reset (rst = 0), at any time, including mid-packet or in HOLD:
  - State goes to ACCUM, first = 1.
  - S, C, ovf_st are cleared.
  - out_valid = 0, out_sum = 0, out_ovf = 0.
  - A partial packet is discarded.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_sum = 0, out_ovf = 0.
- Latency: last beat accepted at edge k; out_sum and out_ovf are registered at edge k+1; out_valid = 1 from edge k+1 (2 cycles after the last beat is presented).
- Output handshake: out_valid is held until the cycle with out_valid & out_ready, and is 0 after that edge.
- in_ready returns to 1 in the cycle after the output handshake; there is no bypass.
- Minimum cost of an n-beat packet: n + 2 cycles.
- in_ready depends only on state, never combinationally on out_ready or in_valid.

## Test plan
Values for W = 8, GUARD = 4.
- Single beat (0xFF, 0xFF, 0xFF, last) -> out_valid 2 cycles later, out_sum = 0x2FD, out_ovf = 0.
- 4 beats of (0xFF, 0xFF, 0xFF) -> out_sum = 0xBF4, out_ovf = 0.
- 6 beats of (0xFF, 0xFF, 0xFF) -> out_sum = 0x1EE, out_ovf = 1 (true sum 4590).
- Backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles in HOLD while driving in_valid.
  - Response: out_sum stable, in_ready = 0, beat not consumed.
  - After out_ready, the next packet (1, 2, 3, last) -> out_sum = 0x006, out_ovf = 0. This proves no residue carries over.
- Packet (0x10, 0x20, 0x30) then (0x01, 0x01, 0x01, last), with 3 idle cycles between the beats -> out_sum = 0x063, identical to the contiguous case.
- Reset mid-packet:
  - Stimulus: assert rst after 2 beats of 0xFF.
  - Response: out_valid = 0, out_sum = 0, in_ready = 1.
  - Then (0x10, 0x20, 0x30, last) -> out_sum = 0x060, out_ovf = 0.
